// File: rtl/arf_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arf_ctrl_pkg
// Description : Shared encodings for the address register file sequencer.
//               Contents: op codes, FunSel functions, RegSel one-hot enables,
//               OutC/OutD source codes and the sequencer state enumeration.
// Revision    : 1.0 - initial release
// ============================================================================
package arf_ctrl_pkg;

    // Operation codes from the instruction controller
    localparam logic [2:0] OP_NOP    = 3'b000;
    localparam logic [2:0] OP_FETCH  = 3'b001;
    localparam logic [2:0] OP_JUMP   = 3'b010;
    localparam logic [2:0] OP_PUSH   = 3'b011;
    localparam logic [2:0] OP_POP    = 3'b100;
    localparam logic [2:0] OP_CALL   = 3'b101;
    localparam logic [2:0] OP_RET    = 3'b110;
    localparam logic [2:0] OP_CLRALL = 3'b111;

    // Register file functions
    localparam logic [1:0] FS_DEC  = 2'b00;
    localparam logic [1:0] FS_INC  = 2'b01;
    localparam logic [1:0] FS_LOAD = 2'b10;
    localparam logic [1:0] FS_CLR  = 2'b11;

    // Register enables: [2] PC, [1] SP, [0] AR
    localparam logic [2:0] SEL_NONE = 3'b000;
    localparam logic [2:0] SEL_PC   = 3'b100;
    localparam logic [2:0] SEL_SP   = 3'b010;
    localparam logic [2:0] SEL_AR   = 3'b001;
    localparam logic [2:0] SEL_ALL  = 3'b111;

    // OutC / OutD source selects
    localparam logic [1:0] OSEL_PC = 2'b00;
    localparam logic [1:0] OSEL_SP = 2'b01;
    localparam logic [1:0] OSEL_AR = 2'b10;

    typedef enum logic [4:0] {
        IDLE  = 5'd0,
        F_RD  = 5'd1,
        F_INC = 5'd2,
        J_LD  = 5'd3,
        P_DEC = 5'd4,
        P_WR  = 5'd5,
        O_RD  = 5'd6,
        O_LD  = 5'd7,
        O_INC = 5'd8,
        C_DEC = 5'd9,
        C_WR  = 5'd10,
        C_LD  = 5'd11,
        R_RD  = 5'd12,
        R_LD  = 5'd13,
        R_INC = 5'd14,
        K_CLR = 5'd15,
        ERR   = 5'd16
    } state_t;

endpackage
`default_nettype wire

// File: rtl/arf_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : arf_seq_ctrl
// Description : Multi-cycle sequencer for the PC/SP/AR address register file.
//               Executes FETCH, JUMP, PUSH, POP, CALL, RET and CLRALL with a
//               req/busy/done handshake and stack bound checking on SP.
// Ports       : clk, rst_n (async active-low)
//               req, op[2:0]      - operation request, sampled in IDLE
//               sp_q[15:0]        - current SP for bound checks
//               busy, done, err   - handshake / status
//               fun_sel, reg_sel  - register file function and enables
//               out_c_sel, out_d_sel, i_sel - datapath source selects
//               mem_rd, mem_wr    - memory strobes (write data is OutC)
// Revision    : 1.0 - initial release
// ============================================================================
module arf_seq_ctrl
    import arf_ctrl_pkg::*;
#(
    parameter logic [15:0] STACK_EMPTY = 16'h0000,
    parameter logic [15:0] STACK_LIMIT = 16'hFF00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic [2:0]  op,
    input  logic [15:0] sp_q,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  fun_sel,
    output logic [2:0]  reg_sel,
    output logic [1:0]  out_c_sel,
    output logic [1:0]  out_d_sel,
    output logic        i_sel,
    output logic        mem_rd,
    output logic        mem_wr
);

    state_t state;
    state_t state_nx;

    logic stack_full;
    logic stack_empty;

    assign stack_full  = (sp_q == STACK_LIMIT);
    assign stack_empty = (sp_q == STACK_EMPTY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state and Moore outputs. The op is not stored separately: the
    // first state of each sequence already identifies the operation.
    always_comb begin
        state_nx  = IDLE;
        busy      = 1'b1;
        done      = 1'b0;
        err       = 1'b0;
        fun_sel   = FS_DEC;
        reg_sel   = SEL_NONE;
        out_c_sel = OSEL_PC;
        out_d_sel = OSEL_PC;
        i_sel     = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;

        case (state)
            IDLE: begin
                busy = 1'b0;
                if (req && (op != OP_NOP)) begin
                    case (op)
                        OP_FETCH:  state_nx = F_RD;
                        OP_JUMP:   state_nx = J_LD;
                        OP_PUSH:   state_nx = stack_full  ? ERR : P_DEC;
                        OP_POP:    state_nx = stack_empty ? ERR : O_RD;
                        OP_CALL:   state_nx = stack_full  ? ERR : C_DEC;
                        OP_RET:    state_nx = stack_empty ? ERR : R_RD;
                        OP_CLRALL: state_nx = K_CLR;
                        default:   state_nx = IDLE;
                    endcase
                end
            end
            F_RD: begin
                state_nx  = F_INC;
                out_d_sel = OSEL_PC;
                mem_rd    = 1'b1;
            end
            F_INC: begin
                reg_sel = SEL_PC;
                fun_sel = FS_INC;
                done    = 1'b1;
            end
            J_LD: begin
                reg_sel = SEL_PC;
                fun_sel = FS_LOAD;
                done    = 1'b1;
            end
            // Full-descending stack: decrement first, then write at new SP
            P_DEC: begin
                state_nx = P_WR;
                reg_sel  = SEL_SP;
                fun_sel  = FS_DEC;
            end
            P_WR: begin
                out_d_sel = OSEL_SP;
                out_c_sel = OSEL_AR;
                mem_wr    = 1'b1;
                done      = 1'b1;
            end
            O_RD: begin
                state_nx  = O_LD;
                out_d_sel = OSEL_SP;
                mem_rd    = 1'b1;
            end
            O_LD: begin
                state_nx = O_INC;
                reg_sel  = SEL_AR;
                fun_sel  = FS_LOAD;
                i_sel    = 1'b1;
            end
            O_INC: begin
                reg_sel = SEL_SP;
                fun_sel = FS_INC;
                done    = 1'b1;
            end
            C_DEC: begin
                state_nx = C_WR;
                reg_sel  = SEL_SP;
                fun_sel  = FS_DEC;
            end
            C_WR: begin
                state_nx  = C_LD;
                out_d_sel = OSEL_SP;
                out_c_sel = OSEL_PC;
                mem_wr    = 1'b1;
            end
            C_LD: begin
                reg_sel = SEL_PC;
                fun_sel = FS_LOAD;
                done    = 1'b1;
            end
            R_RD: begin
                state_nx  = R_LD;
                out_d_sel = OSEL_SP;
                mem_rd    = 1'b1;
            end
            R_LD: begin
                state_nx = R_INC;
                reg_sel  = SEL_PC;
                fun_sel  = FS_LOAD;
                i_sel    = 1'b1;
            end
            R_INC: begin
                reg_sel = SEL_SP;
                fun_sel = FS_INC;
                done    = 1'b1;
            end
            K_CLR: begin
                reg_sel = SEL_ALL;
                fun_sel = FS_CLR;
                done    = 1'b1;
            end
            ERR: begin
                err = 1'b1;
            end
            // Unreachable encodings: drive idle outputs and fall back to IDLE
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_arf_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_arf_seq_ctrl
// Description : Self-checking bench for arf_seq_ctrl. Expected per-cycle
//               output vectors are queued when an operation is issued and
//               compared one per cycle on the falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arf_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic [2:0]  op;
    logic [15:0] sp_q;
    logic        busy, done, err, i_sel, mem_rd, mem_wr;
    logic [1:0]  fun_sel, out_c_sel, out_d_sel;
    logic [2:0]  reg_sel;

    int checks;
    int errors;

    logic [14:0] sb[$];
    logic [14:0] obs;
    logic [14:0] e;

    // {busy, done, err, fun_sel, reg_sel, out_c_sel, out_d_sel, i_sel, mem_rd, mem_wr}
    assign obs = {busy, done, err, fun_sel, reg_sel, out_c_sel, out_d_sel, i_sel, mem_rd, mem_wr};

    localparam logic [14:0] V_IDLE = 15'b0;

    arf_seq_ctrl #(
        .STACK_EMPTY(16'h0000),
        .STACK_LIMIT(16'hFF00)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .op        (op),
        .sp_q      (sp_q),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .fun_sel   (fun_sel),
        .reg_sel   (reg_sel),
        .out_c_sel (out_c_sel),
        .out_d_sel (out_d_sel),
        .i_sel     (i_sel),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Builds a busy-state output vector
    function automatic logic [14:0] bv(input logic dn, input logic er,
                                       input logic [1:0] fs, input logic [2:0] rs,
                                       input logic [1:0] oc, input logic [1:0] od,
                                       input logic is, input logic rd, input logic wr);
        return {1'b1, dn, er, fs, rs, oc, od, is, rd, wr};
    endfunction

    // Expected sequence for one accepted operation, given SP at acceptance
    task automatic push_op(input logic [2:0] o, input logic [15:0] sp);
        case (o)
            3'b001: begin
                sb.push_back(bv(0,0,2'b00,3'b000,2'b00,2'b00,0,1,0));
                sb.push_back(bv(1,0,2'b01,3'b100,2'b00,2'b00,0,0,0));
            end
            3'b010: sb.push_back(bv(1,0,2'b10,3'b100,2'b00,2'b00,0,0,0));
            3'b011: begin
                if (sp == 16'hFF00) sb.push_back(bv(0,1,2'b00,3'b000,2'b00,2'b00,0,0,0));
                else begin
                    sb.push_back(bv(0,0,2'b00,3'b010,2'b00,2'b00,0,0,0));
                    sb.push_back(bv(1,0,2'b00,3'b000,2'b10,2'b01,0,0,1));
                end
            end
            3'b100: begin
                if (sp == 16'h0000) sb.push_back(bv(0,1,2'b00,3'b000,2'b00,2'b00,0,0,0));
                else begin
                    sb.push_back(bv(0,0,2'b00,3'b000,2'b00,2'b01,0,1,0));
                    sb.push_back(bv(0,0,2'b10,3'b001,2'b00,2'b00,1,0,0));
                    sb.push_back(bv(1,0,2'b01,3'b010,2'b00,2'b00,0,0,0));
                end
            end
            3'b101: begin
                if (sp == 16'hFF00) sb.push_back(bv(0,1,2'b00,3'b000,2'b00,2'b00,0,0,0));
                else begin
                    sb.push_back(bv(0,0,2'b00,3'b010,2'b00,2'b00,0,0,0));
                    sb.push_back(bv(0,0,2'b00,3'b000,2'b00,2'b01,0,0,1));
                    sb.push_back(bv(1,0,2'b10,3'b100,2'b00,2'b00,0,0,0));
                end
            end
            3'b110: begin
                if (sp == 16'h0000) sb.push_back(bv(0,1,2'b00,3'b000,2'b00,2'b00,0,0,0));
                else begin
                    sb.push_back(bv(0,0,2'b00,3'b000,2'b00,2'b01,0,1,0));
                    sb.push_back(bv(0,0,2'b10,3'b100,2'b00,2'b00,1,0,0));
                    sb.push_back(bv(1,0,2'b01,3'b010,2'b00,2'b00,0,0,0));
                end
            end
            3'b111: sb.push_back(bv(1,0,2'b11,3'b111,2'b00,2'b00,0,0,0));
            default: ;
        endcase
        sb.push_back(V_IDLE);
    endtask

    // Issue one request for a single cycle, queue expectations, drain queue
    task automatic run_op(input string name, input logic [2:0] o, input logic [15:0] sp);
        @(negedge clk);
        sp_q = sp;
        op   = o;
        req  = 1'b1;
        push_op(o, sp);
        @(posedge clk);
        #1 req = 1'b0;
        while (sb.size() != 0) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL %s op=%0d: got %015b expected %015b", name, o, obs, e);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 1'b0;
        op    = 3'b000;
        sp_q  = 16'h0000;
        repeat (2) @(negedge clk);
        checks++;
        if (obs !== V_IDLE) begin
            errors++;
            $display("FAIL reset: got %015b expected %015b", obs, V_IDLE);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_nop();
        @(negedge clk);
        op  = 3'b000;
        req = 1'b1;
        repeat (2) sb.push_back(V_IDLE);
        while (sb.size() != 0) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL nop: got %015b expected %015b", obs, e);
            end
        end
        req = 1'b0;
    endtask

    task automatic test_ops();
        run_op("fetch",      3'b001, 16'h1234);
        run_op("jump",       3'b010, 16'h1234);
        run_op("push_empty", 3'b011, 16'h0000);
        run_op("push_limit", 3'b011, 16'hFF00);
        run_op("call_limit", 3'b101, 16'hFF00);
        run_op("call",       3'b101, 16'hFF01);
        run_op("ret_empty",  3'b110, 16'h0000);
        run_op("ret",        3'b110, 16'hFFFF);
        run_op("pop_empty",  3'b100, 16'h0000);
        run_op("pop",        3'b100, 16'hFFFE);
        run_op("clrall",     3'b111, 16'h0000);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        sp_q = 16'h4000;
        op   = 3'b010;
        req  = 1'b1;
        repeat (3) push_op(3'b010, 16'h4000);
        while (sb.size() != 0) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL back_to_back: got %015b expected %015b", obs, e);
            end
        end
        req = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        sp_q = 16'h0100;
        op   = 3'b101;
        req  = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        repeat (2) @(negedge clk);
        // Now in C_WR
        checks++;
        if (mem_wr !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_cwr: mem_wr got %b expected 1", mem_wr);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== V_IDLE) begin
            errors++;
            $display("FAIL reset_mid_async: got %015b expected %015b", obs, V_IDLE);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) sb.push_back(V_IDLE);
        while (sb.size() != 0) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL reset_mid_after: got %015b expected %015b", obs, e);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_nop();
        test_ops();
        test_back_to_back();
        run_op("fetch_after_b2b", 3'b001, 16'h0000);
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
